id_ex_ctrl: RTL and testbench

Decode-stage controller for the RV32I 5-stage pipeline. It decodes the ID-stage instruction, drives the immediate-format select and 25-bit immediate field into the immediate extender, and registers the control bundle into the ID/EX boundary. It detects load-use hazards, stalling F/D for one cycle and inserting an EX bubble. It applies branch/jump flushes from EX and keeps saturating stall and flush event counters.

---
 rtl/id_ctrl_pkg.sv | 54 +++++
 rtl/id_ex_ctrl_decode.sv | 74 +++++++
 rtl/id_ex_ctrl.sv | 114 +++++++++++
 tb/tb_id_ex_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ctrl_pkg.sv
// Shared encodings for the RV32I decode-stage controller: opcodes, extender
// immediate select, result/ALU selects and the ID/EX control bundle.
package id_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Values must match the immediate extender's select decoding.
  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_B = 3'b001,
    IMM_S = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } immsrc_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } resultsrc_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } aluop_t;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic       alusrc;
    resultsrc_t resultsrc;
    aluop_t     aluop;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_ctrl_decode.sv
// Combinational opcode decoder: control bits, immediate select and which
// source registers the instruction actually reads.
module ctrl_decode
  import id_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output ctrl_t      ctrl_o,
  output immsrc_t    immsrc_o,
  output logic       use_rs1_o,
  output logic       use_rs2_o
);

  // Register-index and funct fields are left zero; the top overlays them.
  always_comb begin
    ctrl_o    = BUBBLE;
    immsrc_o  = IMM_I;
    use_rs1_o = 1'b0;
    use_rs2_o = 1'b0;
    case (opcode_i)
      OP_LOAD: begin
        ctrl_o.regwrite  = 1'b1;
        ctrl_o.alusrc    = 1'b1;
        ctrl_o.resultsrc = RES_MEM;
        use_rs1_o        = 1'b1;
      end
      OP_ALUI: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.aluop    = ALU_FUNCT;
        use_rs1_o       = 1'b1;
      end
      OP_R: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.aluop    = ALU_FUNCT;
        use_rs1_o       = 1'b1;
        use_rs2_o       = 1'b1;
      end
      OP_STORE: begin
        immsrc_o        = IMM_S;
        ctrl_o.memwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        use_rs1_o       = 1'b1;
        use_rs2_o       = 1'b1;
      end
      OP_BRANCH: begin
        immsrc_o      = IMM_B;
        ctrl_o.branch = 1'b1;
        ctrl_o.aluop  = ALU_SUB;
        use_rs1_o     = 1'b1;
        use_rs2_o     = 1'b1;
      end
      OP_JAL: begin
        immsrc_o         = IMM_J;
        ctrl_o.jump      = 1'b1;
        ctrl_o.regwrite  = 1'b1;
        ctrl_o.resultsrc = RES_PC4;
      end
      OP_JALR: begin
        ctrl_o.jump      = 1'b1;
        ctrl_o.regwrite  = 1'b1;
        ctrl_o.alusrc    = 1'b1;
        ctrl_o.resultsrc = RES_PC4;
        use_rs1_o        = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        immsrc_o        = IMM_U;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_ctrl.sv
// Decode-stage controller: immediate select, load-use stall, EX flush,
// the ID/EX control register and saturating stall/flush event counters.
module id_ex_ctrl
  import id_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      instr_d,
  input  logic             pcsrc_e,
  output logic [2:0]       immsrc_d,
  output logic [24:0]      imm_d,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             regwrite_e,
  output logic             memwrite_e,
  output logic             branch_e,
  output logic             jump_e,
  output logic             alusrc_e,
  output logic [1:0]       resultsrc_e,
  output logic [1:0]       aluop_e,
  output logic [2:0]       funct3_e,
  output logic             funct7b5_e,
  output logic [4:0]       rs1_e,
  output logic [4:0]       rs2_e,
  output logic [4:0]       rd_e,
  output logic             illegal_e,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_t            dec_ctrl;
  immsrc_t          dec_immsrc;
  logic             use_rs1;
  logic             use_rs2;
  logic             lwstall;
  ctrl_t            ex_q, ex_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  ctrl_decode u_decode (
    .opcode_i  (instr_d[6:0]),
    .ctrl_o    (dec_ctrl),
    .immsrc_o  (dec_immsrc),
    .use_rs1_o (use_rs1),
    .use_rs2_o (use_rs2)
  );

  assign immsrc_d = dec_immsrc;
  assign imm_d    = instr_d[31:7];

  assign lwstall = (ex_q.resultsrc == RES_MEM) && (ex_q.rd != 5'd0) &&
                   ((use_rs1 && (instr_d[19:15] == ex_q.rd)) ||
                    (use_rs2 && (instr_d[24:20] == ex_q.rd)));

  // A flush squashes the stalled instruction anyway, so it wins over the stall.
  assign flush_d = pcsrc_e;
  assign stall_f = lwstall & ~pcsrc_e;
  assign stall_d = lwstall & ~pcsrc_e;

  always_comb begin
    ex_d          = dec_ctrl;
    ex_d.funct3   = instr_d[14:12];
    ex_d.funct7b5 = instr_d[30];
    ex_d.rs1      = instr_d[19:15];
    ex_d.rs2      = instr_d[24:20];
    ex_d.rd       = instr_d[11:7];
    if (pcsrc_e || lwstall) begin
      ex_d = BUBBLE;
    end
    stall_cnt_d = stall_cnt_q;
    if (lwstall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    flush_cnt_d = flush_cnt_q;
    if (pcsrc_e && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q        <= BUBBLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign regwrite_e  = ex_q.regwrite;
  assign memwrite_e  = ex_q.memwrite;
  assign branch_e    = ex_q.branch;
  assign jump_e      = ex_q.jump;
  assign alusrc_e    = ex_q.alusrc;
  assign resultsrc_e = ex_q.resultsrc;
  assign aluop_e     = ex_q.aluop;
  assign funct3_e    = ex_q.funct3;
  assign funct7b5_e  = ex_q.funct7b5;
  assign rs1_e       = ex_q.rs1;
  assign rs2_e       = ex_q.rs2;
  assign rd_e        = ex_q.rd;
  assign illegal_e   = ex_q.illegal;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_ctrl.sv
// Bench for id_ex_ctrl: directed scenarios plus randomized instruction
// streams checked against an instruction-level reference model.
module tb_id_ex_ctrl;

  localparam int EXW = 29;
  localparam int QW  = EXW + 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr_d;
  logic        pcsrc_e;
  logic [2:0]  immsrc_d;
  logic [24:0] imm_d;
  logic        stall_f, stall_d, flush_d;
  logic        regwrite_e, memwrite_e, branch_e, jump_e, alusrc_e;
  logic [1:0]  resultsrc_e, aluop_e;
  logic [2:0]  funct3_e;
  logic        funct7b5_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic        illegal_e;
  logic [15:0] stall_cnt, flush_cnt;

  // Narrow-counter instance used only to reach saturation quickly.
  logic        sm_rst_n;
  logic        sm_pcsrc;
  logic [31:0] sm_instr;
  logic [2:0]  sm_immsrc;
  logic [24:0] sm_imm;
  logic        sm_stall_f, sm_stall_d, sm_flush_d;
  logic        sm_regwrite, sm_memwrite, sm_branch, sm_jump, sm_alusrc;
  logic [1:0]  sm_resultsrc, sm_aluop;
  logic [2:0]  sm_funct3;
  logic        sm_funct7b5;
  logic [4:0]  sm_rs1, sm_rs2, sm_rd;
  logic        sm_illegal;
  logic [3:0]  sm_stall_cnt, sm_flush_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  logic [QW-1:0] exp_q[$];

  // Reference model state: what instruction sits in EX and the event tallies.
  logic        m_ex_is_load;
  logic [4:0]  m_ex_rd;
  int          m_stall;
  int          m_flush;

  id_ex_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .instr_d(instr_d), .pcsrc_e(pcsrc_e),
    .immsrc_d(immsrc_d), .imm_d(imm_d), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .regwrite_e(regwrite_e), .memwrite_e(memwrite_e),
    .branch_e(branch_e), .jump_e(jump_e), .alusrc_e(alusrc_e),
    .resultsrc_e(resultsrc_e), .aluop_e(aluop_e), .funct3_e(funct3_e),
    .funct7b5_e(funct7b5_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .illegal_e(illegal_e), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_ctrl #(.CNT_W(4)) dut_sm (
    .clk(clk), .reset_n(sm_rst_n), .instr_d(sm_instr), .pcsrc_e(sm_pcsrc),
    .immsrc_d(sm_immsrc), .imm_d(sm_imm), .stall_f(sm_stall_f), .stall_d(sm_stall_d),
    .flush_d(sm_flush_d), .regwrite_e(sm_regwrite), .memwrite_e(sm_memwrite),
    .branch_e(sm_branch), .jump_e(sm_jump), .alusrc_e(sm_alusrc),
    .resultsrc_e(sm_resultsrc), .aluop_e(sm_aluop), .funct3_e(sm_funct3),
    .funct7b5_e(sm_funct7b5), .rs1_e(sm_rs1), .rs2_e(sm_rs2), .rd_e(sm_rd),
    .illegal_e(sm_illegal), .stall_cnt(sm_stall_cnt), .flush_cnt(sm_flush_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  function automatic logic [EXW-1:0] dut_ex();
    return {regwrite_e, memwrite_e, branch_e, jump_e, alusrc_e, resultsrc_e, aluop_e,
            funct3_e, funct7b5_e, rs1_e, rs2_e, rd_e, illegal_e};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level reference: control word per opcode as listed for the ISA subset.
  // ctl = {regwrite, memwrite, branch, jump, alusrc, resultsrc[1:0], aluop[1:0]}
  task automatic model_decode(input logic [31:0] ins, output logic [EXW-1:0] ex,
                              output logic [2:0] sel, output logic u1, output logic u2);
    logic [8:0] ctl;
    logic       ill;
    ill = 1'b0;
    case (ins[6:0])
      7'b0000011: begin ctl = 9'b10001_01_00; sel = 3'd0; u1 = 1; u2 = 0; end
      7'b0010011: begin ctl = 9'b10001_00_10; sel = 3'd0; u1 = 1; u2 = 0; end
      7'b0110011: begin ctl = 9'b10000_00_10; sel = 3'd0; u1 = 1; u2 = 1; end
      7'b0100011: begin ctl = 9'b01001_00_00; sel = 3'd2; u1 = 1; u2 = 1; end
      7'b1100011: begin ctl = 9'b00100_00_01; sel = 3'd1; u1 = 1; u2 = 1; end
      7'b1101111: begin ctl = 9'b10010_10_00; sel = 3'd3; u1 = 0; u2 = 0; end
      7'b1100111: begin ctl = 9'b10011_10_00; sel = 3'd0; u1 = 1; u2 = 0; end
      7'b0110111,
      7'b0010111: begin ctl = 9'b10001_00_00; sel = 3'd4; u1 = 0; u2 = 0; end
      default:    begin ctl = 9'b0;           sel = 3'd0; u1 = 0; u2 = 0; ill = 1'b1; end
    endcase
    ex = {ctl, ins[14:12], ins[30], ins[19:15], ins[24:20], ins[11:7], ill};
  endtask

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // ---------------- driver ----------------
  // One ID-stage cycle: drive, check the zero-latency outputs, predict EX.
  task automatic step(input logic [31:0] ins, input logic pc, output logic stalled);
    logic [EXW-1:0] ex;
    logic [2:0]     sel;
    logic           u1, u2, hazard;
    @(negedge clk);
    instr_d = ins;
    pcsrc_e = pc;
    #1;
    model_decode(ins, ex, sel, u1, u2);
    hazard = m_ex_is_load && (m_ex_rd != 5'd0) &&
             ((u1 && ins[19:15] == m_ex_rd) || (u2 && ins[24:20] == m_ex_rd));
    check("immsrc_d", 64'(immsrc_d), 64'(sel));
    check("imm_d", 64'(imm_d), 64'(ins[31:7]));
    check("stall_f", 64'(stall_f), 64'(hazard && !pc));
    check("stall_d", 64'(stall_d), 64'(hazard && !pc));
    check("flush_d", 64'(flush_d), 64'(pc));
    if (hazard) m_stall = sat16(m_stall);
    if (pc)     m_flush = sat16(m_flush);
    if (pc || hazard) begin
      ex = '0;
      m_ex_is_load = 1'b0;
      m_ex_rd = 5'd0;
    end else begin
      m_ex_is_load = (ins[6:0] == 7'b0000011);
      m_ex_rd = ins[11:7];
    end
    exp_q.push_back({ex, 16'(m_stall), 16'(m_flush)});
    stalled = hazard && !pc;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10] = '{7'b0000011, 7'b0010011, 7'b0110011, 7'b0100011, 7'b1100011,
                              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
    logic [31:0] i;
    i = $urandom;
    i[6:0]   = ($urandom_range(0, 11) < 10) ? ops[$urandom_range(0, 9)] : 7'($urandom);
    i[11:7]  = 5'($urandom_range(0, 3));
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    return i;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [QW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ex_bundle", 64'(dut_ex()), 64'(e[QW-1:32]));
        check("stall_cnt", 64'(stall_cnt), 64'(e[31:16]));
        check("flush_cnt", 64'(flush_cnt), 64'(e[15:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [31:0] LW_X5_4_X1  = {12'd4, 5'd1, 3'b010, 5'd5, 7'b0000011};
  localparam logic [31:0] LW_X5_0_X1  = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
  localparam logic [31:0] LW_X0_0_X1  = {12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011};
  localparam logic [31:0] ADD_6_5_2   = {7'd0, 5'd2, 5'd5, 3'b000, 5'd6, 7'b0110011};
  localparam logic [31:0] ADD_6_0_2   = {7'd0, 5'd2, 5'd0, 3'b000, 5'd6, 7'b0110011};
  localparam logic [31:0] LUI_X5      = {20'h12345, 5'd5, 7'b0110111};
  localparam logic [31:0] ADDI_X1     = {12'h7ff, 5'd2, 3'b000, 5'd1, 7'b0010011};
  localparam logic [31:0] BEQ         = {7'b1010101, 5'd3, 5'd4, 3'b000, 5'b01011, 7'b1100011};
  localparam logic [31:0] SW          = {7'b0000001, 5'd7, 5'd8, 3'b010, 5'b00100, 7'b0100011};
  localparam logic [31:0] JAL         = {20'hABCDE, 5'd1, 7'b1101111};
  localparam logic [31:0] NOP         = 32'h0000_0013;
  localparam logic [31:0] ILLEGAL     = {25'h1ABCDEF, 7'b1111111};

  initial begin
    logic        st;
    logic [31:0] ins;
    logic        pc;

    reset_n = 1'b0;
    instr_d = LW_X5_4_X1;
    pcsrc_e = 1'b0;
    sm_rst_n = 1'b0;
    sm_pcsrc = 1'b0;
    sm_instr = NOP;
    m_ex_is_load = 1'b0;
    m_ex_rd = 5'd0;
    m_stall = 0;
    m_flush = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("reset_ex", 64'(dut_ex()), 64'd0);
    check("reset_stall_cnt", 64'(stall_cnt), 64'd0);
    check("reset_flush_cnt", 64'(flush_cnt), 64'd0);
    check("reset_stall_f", 64'(stall_f), 64'd0);
    check("reset_imm_d", 64'(imm_d), 64'(LW_X5_4_X1[31:7]));
    @(negedge clk);
    reset_n = 1'b1;

    // Immediate select across formats
    step(ADDI_X1, 1'b0, st);
    step(BEQ, 1'b0, st);
    step(SW, 1'b0, st);
    step(JAL, 1'b0, st);
    step(LUI_X5, 1'b0, st);

    // Load-use: stall one cycle, then the add proceeds
    step(LW_X5_0_X1, 1'b0, st);
    step(ADD_6_5_2, 1'b0, st);
    check("lwstall_asserted", 64'(st), 64'd1);
    step(ADD_6_5_2, 1'b0, st);
    check("lwstall_one_cycle", 64'(st), 64'd0);
    @(posedge clk);
    #2;
    check("add_in_ex_rs1", 64'(rs1_e), 64'd5);
    check("stall_cnt_one", 64'(stall_cnt), 64'd1);

    // No false stalls
    step(LW_X0_0_X1, 1'b0, st);
    step(ADD_6_0_2, 1'b0, st);
    step(LW_X5_0_X1, 1'b0, st);
    step(LUI_X5, 1'b0, st);

    // Flush, then flush colliding with a load-use hazard
    step(ADDI_X1, 1'b1, st);
    @(posedge clk);
    #2;
    check("flush_cnt_one", 64'(flush_cnt), 64'd1);
    step(LW_X5_0_X1, 1'b0, st);
    step(ADD_6_5_2, 1'b1, st);
    check("flush_over_stall", 64'(stall_f), 64'd0);

    // Illegal opcode
    step(ILLEGAL, 1'b0, st);
    @(posedge clk);
    #2;
    check("illegal_e", 64'(illegal_e), 64'd1);
    check("illegal_regwrite", 64'(regwrite_e), 64'd0);

    // Randomized stream; a stalled instruction is re-presented like a held IF/ID
    ins = rand_instr();
    for (int n = 0; n < 2000; n++) begin
      pc = ($urandom_range(0, 7) == 0);
      step(ins, pc, st);
      if (!st) ins = rand_instr();
    end

    // Asynchronous reset mid-operation discards the EX instruction
    step(NOP, 1'b0, st);
    step(LW_X5_0_X1, 1'b0, st);
    @(posedge clk);
    #3;
    check("pre_reset_ex_nonzero", 64'(dut_ex() != '0), 64'd1);
    reset_n = 1'b0;
    instr_d = ADD_6_5_2;
    #1;
    check("async_reset_ex", 64'(dut_ex()), 64'd0);
    check("async_reset_stall_cnt", 64'(stall_cnt), 64'd0);
    check("async_reset_flush_cnt", 64'(flush_cnt), 64'd0);
    check("async_reset_stall_f", 64'(stall_f), 64'd0);
    exp_q.delete();
    m_ex_is_load = 1'b0;
    m_ex_rd = 5'd0;
    m_stall = 0;
    m_flush = 0;
    @(negedge clk);
    reset_n = 1'b1;
    step(ADD_6_5_2, 1'b0, st);
    step(NOP, 1'b0, st);

    // Counter saturation on the narrow instance
    @(negedge clk);
    sm_rst_n = 1'b1;
    sm_pcsrc = 1'b1;
    repeat (15) @(posedge clk);
    #2;
    check("sat_reach_max", 64'(sm_flush_cnt), 64'hF);
    repeat (5) @(posedge clk);
    #2;
    check("sat_hold_max", 64'(sm_flush_cnt), 64'hF);
    check("sat_stall_cnt", 64'(sm_stall_cnt), 64'd0);
    @(negedge clk);
    sm_pcsrc = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
